// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file arbiter.
//   state_t        : controller state (clear sequence / serving requests)
//   PORT0, PORT1   : requester indices
//   BWEB_IDLE_BIT  : per-bit value of the active-low bit-write enable when idle
package rf_ctrl_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic BWEB_IDLE_BIT = 1'b1;

  // The port that gets priority after the given port was served.
  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-port request
//   advance  : a grant was consumed this cycle; hand priority to the other port
//   gnt      : one-hot grant (combinational from req and the priority pointer)
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic rr_ptr;

  // Pointer only breaks ties; a lone request is always granted.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt[rr_ptr] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= PORT0;
    end else if (advance) begin
      rr_ptr <= other_port(gnt[PORT1] ? PORT1 : PORT0);
    end
  end

endmodule

// File: rtl/rf_arbiter.sv
// Shares one single-port register-file macro between a host port (0) and a
// compute port (1). Clears every row after reset, then serves one access per
// cycle with round-robin arbitration and returns registered read data.
//   CLK, RST                 : clock, synchronous active-high reset
//   init_done                : clear sequence finished
//   rN_valid/ready/we/addr/wdata : request channel, N = 0, 1
//   rN_rvalid/rdata          : one-cycle read response
//   mem_CEB/WEB/A/D/BWEB     : macro pins (active-low enables)
//   mem_Q                    : macro read data, combinational from mem_A
module rf_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROW      = 16,
  parameter int unsigned NUM_BIT      = 8,
  parameter int unsigned NUM_ROW_ADDR = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic                    init_done,
  input  logic                    r0_valid,
  output logic                    r0_ready,
  input  logic                    r0_we,
  input  logic [NUM_ROW_ADDR-1:0] r0_addr,
  input  logic [NUM_BIT-1:0]      r0_wdata,
  output logic                    r0_rvalid,
  output logic [NUM_BIT-1:0]      r0_rdata,
  input  logic                    r1_valid,
  output logic                    r1_ready,
  input  logic                    r1_we,
  input  logic [NUM_ROW_ADDR-1:0] r1_addr,
  input  logic [NUM_BIT-1:0]      r1_wdata,
  output logic                    r1_rvalid,
  output logic [NUM_BIT-1:0]      r1_rdata,
  output logic                    mem_CEB,
  output logic                    mem_WEB,
  output logic [NUM_ROW_ADDR-1:0] mem_A,
  output logic [NUM_BIT-1:0]      mem_D,
  output logic [NUM_BIT-1:0]      mem_BWEB,
  input  logic [NUM_BIT-1:0]      mem_Q
);

  localparam int unsigned CMP_W = NUM_ROW_ADDR + 1;

  state_t                  state;
  state_t                  state_nxt;
  logic [NUM_ROW_ADDR-1:0] clr_cnt;
  logic [1:0]              req;
  logic [1:0]              gnt;
  logic                    sel_we;
  logic [NUM_ROW_ADDR-1:0] sel_addr;
  logic [NUM_BIT-1:0]      sel_wdata;
  logic                    in_range;
  logic                    clr_last;
  logic                    rd_acc0;
  logic                    rd_acc1;
  logic [NUM_BIT-1:0]      rsp_data;

  // Requests are only visible to the arbiter once the clear has finished.
  assign req = {r1_valid, r0_valid} & {2{state == ST_SERVE}};

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst     (RST),
    .req     (req),
    .advance (|gnt),
    .gnt     (gnt)
  );

  assign r0_ready = gnt[PORT0];
  assign r1_ready = gnt[PORT1];

  assign sel_we    = gnt[PORT1] ? r1_we    : r0_we;
  assign sel_addr  = gnt[PORT1] ? r1_addr  : r0_addr;
  assign sel_wdata = gnt[PORT1] ? r1_wdata : r0_wdata;

  // Extra compare bit so NUM_ROW == 2**NUM_ROW_ADDR is representable.
  assign in_range = CMP_W'(sel_addr) < CMP_W'(NUM_ROW);
  assign clr_last = clr_cnt == NUM_ROW_ADDR'(NUM_ROW - 1);

  assign rd_acc0  = gnt[PORT0] & ~r0_we;
  assign rd_acc1  = gnt[PORT1] & ~r1_we;
  assign rsp_data = in_range ? mem_Q : '0;

  // State, clear counter and done flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == ST_SERVE);
      if (state == ST_INIT) begin
        clr_cnt <= clr_cnt + NUM_ROW_ADDR'(1);
      end
    end
  end

  // Next state and macro pin mux.
  always_comb begin
    state_nxt = state;
    mem_CEB   = 1'b1;
    mem_WEB   = 1'b1;
    mem_A     = '0;
    mem_D     = '0;
    mem_BWEB  = {NUM_BIT{BWEB_IDLE_BIT}};
    case (state)
      ST_INIT: begin
        mem_CEB  = 1'b0;
        mem_WEB  = 1'b0;
        mem_A    = clr_cnt;
        mem_BWEB = '0;
        if (clr_last) begin
          state_nxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // Out-of-range accesses are accepted but leave the macro untouched.
        if ((|gnt) && in_range) begin
          mem_CEB = 1'b0;
          mem_WEB = ~sel_we;
          mem_A   = sel_addr;
          if (sel_we) begin
            mem_D    = sel_wdata;
            mem_BWEB = '0;
          end
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Read responses: one-cycle valid, data held between responses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= rd_acc0;
      r1_rvalid <= rd_acc1;
      if (rd_acc0) begin
        r0_rdata <= rsp_data;
      end
      if (rd_acc1) begin
        r1_rdata <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_arbiter.sv
// Bench for rf_arbiter: a 16-row instance for the main checks and a 12-row
// instance (same stimulus) for the out-of-range case, each with a behavioural
// macro model.
module tb_rf_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       CLK;
  logic       RST;
  logic       bd_fill;
  logic       r0_valid, r0_we, r1_valid, r1_we;
  logic [3:0] r0_addr, r1_addr;
  logic [7:0] r0_wdata, r1_wdata;

  // 16-row instance
  logic       init_done, r0_ready, r1_ready, r0_rvalid, r1_rvalid;
  logic [7:0] r0_rdata, r1_rdata;
  logic       mem_CEB, mem_WEB;
  logic [3:0] mem_A;
  logic [7:0] mem_D, mem_BWEB, mem_Q;
  logic [7:0] mem [16];

  // 12-row instance
  logic       init_done_b, r0_ready_b, r1_ready_b, r0_rvalid_b, r1_rvalid_b;
  logic [7:0] r0_rdata_b, r1_rdata_b;
  logic       mem_CEB_b, mem_WEB_b;
  logic [3:0] mem_A_b;
  logic [7:0] mem_D_b, mem_BWEB_b, mem_Q_b;
  logic [7:0] mem_b [16];

  int checks = 0;
  int errors = 0;

  rf_arbiter #(.NUM_ROW(16), .NUM_BIT(8), .NUM_ROW_ADDR(4)) dut (
    .CLK(CLK), .RST(RST), .init_done(init_done),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_CEB(mem_CEB), .mem_WEB(mem_WEB), .mem_A(mem_A), .mem_D(mem_D),
    .mem_BWEB(mem_BWEB), .mem_Q(mem_Q)
  );

  rf_arbiter #(.NUM_ROW(12), .NUM_BIT(8), .NUM_ROW_ADDR(4)) dut12 (
    .CLK(CLK), .RST(RST), .init_done(init_done_b),
    .r0_valid(r0_valid), .r0_ready(r0_ready_b), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid_b), .r0_rdata(r0_rdata_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready_b), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid_b), .r1_rdata(r1_rdata_b),
    .mem_CEB(mem_CEB_b), .mem_WEB(mem_WEB_b), .mem_A(mem_A_b), .mem_D(mem_D_b),
    .mem_BWEB(mem_BWEB_b), .mem_Q(mem_Q_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Macro models: combinational read, bit-masked write, backdoor fill.
  assign mem_Q   = mem[mem_A];
  assign mem_Q_b = mem_b[mem_A_b];

  always @(posedge CLK) begin
    if (bd_fill) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]   <= 8'hFF;
        mem_b[i] <= 8'hFF;
      end
    end else begin
      if (!mem_CEB && !mem_WEB)
        mem[mem_A] <= (mem[mem_A] & mem_BWEB) | (mem_D & ~mem_BWEB);
      if (!mem_CEB_b && !mem_WEB_b)
        mem_b[mem_A_b] <= (mem_b[mem_A_b] & mem_BWEB_b) | (mem_D_b & ~mem_BWEB_b);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [3:0] a0, input logic [7:0] d0,
                       input logic v1, input logic we1, input logic [3:0] a1, input logic [7:0] d1);
    r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
  endtask

  // Expect the clear sequence of the 16-row instance, starting at row 0 in the current cycle.
  task automatic check_clear();
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("clr_web_%0d", k), 8'(mem_WEB), 8'(L));
      check($sformatf("clr_ceb_%0d", k), 8'(mem_CEB), 8'(L));
      check($sformatf("clr_a_%0d", k), 8'(mem_A), 8'(k));
      check($sformatf("clr_d_%0d", k), mem_D, 8'h00);
      check($sformatf("clr_bweb_%0d", k), mem_BWEB, 8'h00);
      check($sformatf("clr_rdy0_%0d", k), 8'(r0_ready), 8'(L));
      check($sformatf("clr_done_%0d", k), 8'(init_done), 8'(L));
      tick();
    end
  endtask

  typedef struct {
    logic       v0, we0; logic [3:0] a0; logic [7:0] d0;
    logic       v1, we1; logic [3:0] a1; logic [7:0] d1;
    logic       rdy0, rdy1, ceb, web; logic [3:0] a;
    logic       rv0; logic [7:0] rd0; logic rv1; logic [7:0] rd1;
  } vec_t;

  vec_t tbl [15];

  initial begin
    //          v0 we0 a0    d0     v1 we1 a1    d1     rdy0 rdy1 ceb web a      rv0 rd0    rv1 rd1
    tbl[0]  = '{H, H, 4'd3, 8'hA5, L, L, 4'd0, 8'h00, H, L, L, L, 4'd3, H, 8'h00, L, 8'h00};
    tbl[1]  = '{H, L, 4'd3, 8'h00, L, L, 4'd0, 8'h00, H, L, L, H, 4'd3, L, 8'h00, L, 8'h00};
    tbl[2]  = '{L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00, L, L, H, H, 4'd0, H, 8'hA5, L, 8'h00};
    tbl[3]  = '{L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00, L, L, H, H, 4'd0, L, 8'hA5, L, 8'h00};
    tbl[4]  = '{H, H, 4'd1, 8'h11, L, L, 4'd0, 8'h00, H, L, L, L, 4'd1, L, 8'hA5, L, 8'h00};
    tbl[5]  = '{L, L, 4'd0, 8'h00, H, H, 4'd2, 8'h22, L, H, L, L, 4'd2, L, 8'hA5, L, 8'h00};
    tbl[6]  = '{H, L, 4'd1, 8'h00, H, L, 4'd2, 8'h00, H, L, L, H, 4'd1, L, 8'hA5, L, 8'h00};
    tbl[7]  = '{H, L, 4'd1, 8'h00, H, L, 4'd2, 8'h00, L, H, L, H, 4'd2, H, 8'h11, L, 8'h00};
    tbl[8]  = '{H, L, 4'd1, 8'h00, H, L, 4'd2, 8'h00, H, L, L, H, 4'd1, L, 8'h11, H, 8'h22};
    tbl[9]  = '{H, L, 4'd1, 8'h00, H, L, 4'd2, 8'h00, L, H, L, H, 4'd2, H, 8'h11, L, 8'h22};
    tbl[10] = '{L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00, L, L, H, H, 4'd0, L, 8'h11, H, 8'h22};
    tbl[11] = '{L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00, L, L, H, H, 4'd0, L, 8'h11, L, 8'h22};
    tbl[12] = '{L, L, 4'd0, 8'h00, H, H, 4'd5, 8'h3C, L, H, L, L, 4'd5, L, 8'h11, L, 8'h22};
    tbl[13] = '{L, L, 4'd0, 8'h00, H, L, 4'd5, 8'h00, L, H, L, H, 4'd5, L, 8'h11, L, 8'h22};
    tbl[14] = '{L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00, L, L, H, H, 4'd0, L, 8'h11, H, 8'h3C};

    // Reset with rows pre-filled to FF; port 0 already requesting a read of row 0.
    RST = 1'b1;
    bd_fill = 1'b1;
    drive(H, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00);
    repeat (3) @(posedge CLK);
    #1;
    bd_fill = 1'b0;
    RST = 1'b0;
    check("rst_init_done", 8'(init_done), 8'(L));
    check("rst_r0_rvalid", 8'(r0_rvalid), 8'(L));
    check("rst_r1_rvalid", 8'(r1_rvalid), 8'(L));
    check("rst_r0_rdata", r0_rdata, 8'h00);
    check("rst_r1_rdata", r1_rdata, 8'h00);

    check_clear();

    // First SERVE cycle: the pending read is accepted immediately.
    #1;
    check("serve_init_done", 8'(init_done), 8'(H));
    check("serve_r0_ready", 8'(r0_ready), 8'(H));
    check("serve_web", 8'(mem_WEB), 8'(H));
    check("serve_a", 8'(mem_A), 8'h00);
    tick();
    r0_addr = 4'd15;
    #1;
    check("row0_rvalid", 8'(r0_rvalid), 8'(H));
    check("row0_rdata", r0_rdata, 8'h00);
    check("row15_ready", 8'(r0_ready), 8'(H));
    tick();

    // Directed vectors: single-port write/read, contention, read-after-write.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
      #1;
      check($sformatf("v%0d_rdy0", i), 8'(r0_ready), 8'(tbl[i].rdy0));
      check($sformatf("v%0d_rdy1", i), 8'(r1_ready), 8'(tbl[i].rdy1));
      check($sformatf("v%0d_ceb", i), 8'(mem_CEB), 8'(tbl[i].ceb));
      check($sformatf("v%0d_web", i), 8'(mem_WEB), 8'(tbl[i].web));
      check($sformatf("v%0d_a", i), 8'(mem_A), 8'(tbl[i].a));
      check($sformatf("v%0d_rv0", i), 8'(r0_rvalid), 8'(tbl[i].rv0));
      check($sformatf("v%0d_rd0", i), r0_rdata, tbl[i].rd0);
      check($sformatf("v%0d_rv1", i), 8'(r1_rvalid), 8'(tbl[i].rv1));
      check($sformatf("v%0d_rd1", i), r1_rdata, tbl[i].rd1);
      if (tbl[i].ceb == L && tbl[i].web == L) begin
        check($sformatf("v%0d_d", i), mem_D, tbl[i].rdy1 ? tbl[i].d1 : tbl[i].d0);
        check($sformatf("v%0d_bweb", i), mem_BWEB, 8'h00);
      end
      if (tbl[i].ceb == H) begin
        check($sformatf("v%0d_idle_d", i), mem_D, 8'h00);
        check($sformatf("v%0d_idle_bweb", i), mem_BWEB, 8'hFF);
      end
      tick();
    end

    // Out-of-range read on the 12-row instance.
    drive(L, L, 4'd0, 8'h00, H, L, 4'd13, 8'h00);
    #1;
    check("oor_ready", 8'(r1_ready_b), 8'(H));
    check("oor_ceb", 8'(mem_CEB_b), 8'(H));
    tick();
    drive(L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00);
    #1;
    check("oor_rvalid", 8'(r1_rvalid_b), 8'(H));
    check("oor_rdata", r1_rdata_b, 8'h00);
    tick();

    // Reset during an accepted read: no response, clear reruns from row 0.
    drive(H, L, 4'd3, 8'h00, L, L, 4'd0, 8'h00);
    RST = 1'b1;
    #1;
    check("mid_rst_ready", 8'(r0_ready), 8'(H));
    tick();
    RST = 1'b0;
    drive(L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00);
    #1;
    check("mid_rst_rvalid", 8'(r0_rvalid), 8'(L));
    check("mid_rst_done", 8'(init_done), 8'(L));
    check_clear();
    #1;
    check("rerun_done", 8'(init_done), 8'(H));
    drive(H, L, 4'd3, 8'h00, L, L, 4'd0, 8'h00);
    #1;
    check("rerun_q", mem_Q, 8'h00);
    tick();
    drive(L, L, 4'd0, 8'h00, L, L, 4'd0, 8'h00);
    #1;
    check("rerun_rvalid", 8'(r0_rvalid), 8'(H));
    check("rerun_rdata", r0_rdata, 8'h00);
    tick();
    #1;
    check("rerun_rvalid_drop", 8'(r0_rvalid), 8'(L));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_arbiter.md
Name: rf_arbiter

Overview:
- Shares one single-port register-file macro between two requesters: port 0 (host/config) and port 1 (compute engine).
- After reset, sequences a full clear of the macro (all rows written to 0).
- Then serves one read or write per cycle under round-robin arbitration.
- Drives the macro pins directly and returns registered read data to the requester that issued the read.

Parameters:
- NUM_ROW, 16, number of macro rows; must be ≤ 2**NUM_ROW_ADDR.
- NUM_BIT, 8, data width.
- NUM_ROW_ADDR, 4, address width.

Ports:
- CLK  in  1  clock; all state on rising edge
- RST  in  1  synchronous reset, active-high
- init_done  out  1  high once clear sequence completes
- rN_valid  in  1  request valid (N = 0, 1; all rN_* ports exist for both)
- rN_ready  out  1  request accepted this cycle
- rN_we  in  1  1 = write, 0 = read
- rN_addr  in  NUM_ROW_ADDR  row address
- rN_wdata  in  NUM_BIT  write data
- rN_rvalid  out  1  read response valid, one-cycle pulse
- rN_rdata  out  NUM_BIT  read response data
- mem_CEB  out  1  macro chip enable, active-low
- mem_WEB  out  1  macro write enable, active-low
- mem_A  out  NUM_ROW_ADDR  macro address
- mem_D  out  NUM_BIT  macro write data
- mem_BWEB  out  NUM_BIT  macro bit-write enable, active-low
- mem_Q  in  NUM_BIT  macro read data; combinational from mem_A

Behaviour:
- Reset (RST=1 at edge):
  - state=ST_INIT, clr_cnt=0, rr_ptr=0 (port 0 favoured).
  - init_done=0, rN_rvalid=0, rN_rdata=0.
  - Reset asserted mid-INIT or mid-SERVE restarts the clear sequence and drops any pending rvalid.
- ST_INIT:
  - Every cycle drive mem_CEB=0, mem_WEB=0, mem_A=clr_cnt, mem_D=0, mem_BWEB=0.
  - clr_cnt increments each cycle.
  - On the edge that writes row NUM_ROW-1, go to ST_SERVE and set init_done=1 (registered).
  - Net effect: first SERVE cycle is NUM_ROW cycles after RST deasserts.
  - rN_ready=0 throughout.
- ST_SERVE, readiness and grant:
  - rN_ready = (state==ST_SERVE) && grant==N. Combinational from valids.
  - Requesters must not make valid depend on ready.
  - Grant, one valid: grant that port.
  - Grant, both valid: grant port rr_ptr.
  - On every accepted transaction, rr_ptr := other port than the one granted.
  - A requester holds valid and fields stable until ready.
- ST_SERVE, accepted write:
  - mem_CEB=0, mem_WEB=0, mem_A=addr, mem_D=wdata, mem_BWEB=0.
  - Writes produce no response.
- ST_SERVE, accepted read:
  - mem_CEB=0, mem_WEB=1, mem_A=addr.
  - rN_rdata <= mem_Q at that edge; rN_rvalid=1 for exactly the next cycle.
  - Latency = 1 cycle.
  - rdata holds its last value while rvalid=0.
- Idle cycle (no grant):
  - mem_CEB=1, mem_WEB=1, mem_A=0, mem_D=0, mem_BWEB all ones.
- Out-of-range address (addr ≥ NUM_ROW):
  - Request still accepted, but mem_CEB=1 (macro untouched).
  - A read returns rdata=0 with rvalid=1 next cycle.
- Hazards:
  - Read-after-write to the same row in consecutive cycles returns the new data.
  - Only one access per cycle, so there are no same-cycle conflicts.
- Back-to-back reads from one port give rvalid high on consecutive cycles.

Decomposition:
- Package rf_ctrl_pkg:
  - state enum {ST_INIT, ST_SERVE}
  - constants PORT0=0, PORT1=1
  - localparam for the idle BWEB value (all ones)
- Sub-module rr_arb2:
  - Two-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: gnt[1:0], holds rr_ptr.
- Top level: INIT FSM/counter, macro pin mux, response registers.

Test Plan:
- Clear sequence: write 8'hFF to rows 0–15 via a pre-reset backdoor, pulse RST → mem_WEB=0 for exactly 16 cycles, mem_A 0..15, init_done rises 16 cycles after RST falls; subsequent reads of rows 0 and 15 return 8'h00.
- Single port: r0 writes 8'hA5 to row 3, next cycle r0 reads row 3 → r0_rvalid=1 one cycle later with r0_rdata=8'hA5; r1_rvalid stays 0.
- Contention: both ports hold valid reads (rows 1, 2) for 4 cycles after init → grants alternate 0,1,0,1; each port gets exactly 2 rvalid pulses with correct data.
- Out of range: NUM_ROW=12, r1 reads addr 13 → mem_CEB=1 that cycle, r1_rvalid=1 next cycle with r1_rdata=8'h00.
- Reset mid-operation: assert RST during a SERVE read cycle → rvalid does not pulse afterward; init_done=0 and the clear sequence reruns from row 0.
- Requests during INIT: r0_valid=1 throughout INIT → r0_ready=0 until init_done=1, then accepted in the first SERVE cycle.
